// File: rtl/axi_read_intf_pkg.sv
// Shared encodings for the AXI read-side slave interface: burst, response and
// region codes, the FSM state type and the beat-size clamp.
package axi_read_intf_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      REGION_FIFO = 2'd0,
      REGION_IRAM = 2'd1,
      REGION_WRAM = 2'd2,
      REGION_RSVD = 2'd3
   } region_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } rd_state_t;

   localparam int SIZE_MAX = 2;

   // Beats are at most 4 bytes wide, so larger sizes collapse to 4 bytes.
   function automatic logic [1:0] clamp_size(input logic [2:0] size);
      return (size > 3'(SIZE_MAX)) ? 2'(SIZE_MAX) : size[1:0];
   endfunction

endpackage

// File: rtl/axi_rd_skid_buf.sv
// Two-entry FIFO that holds R-channel beats ({data, id, resp, last}) so the
// read engine can keep running while the master applies RREADY backpressure.
module axi_rd_skid_buf #(
   parameter int WIDTH = 43
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic [WIDTH-1:0] entry0;
   logic [WIDTH-1:0] entry1;
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             push;
   logic             pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = rd_ptr ? entry1 : entry0;

   // The head entry is only ever written while the buffer is empty, so the
   // presented payload cannot change under a stalled RVALID.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry0 <= '0;
         entry1 <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         assert (!(in_valid && !in_ready));
         if (push) begin
            if (wr_ptr) begin
               entry1 <= in_data;
            end else begin
               entry0 <= in_data;
            end
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/axi_read_intf.sv
// AXI4 read-side slave: one burst at a time, one single-beat internal request
// at a time, beats returned through a 2-entry skid buffer.
// Optional WRAP burst support is enabled by defining AXI_RD_WRAP_BURST_EN.
module axi_read_intf
   import axi_read_intf_pkg::*;
#(
   parameter int ARID_WIDTH   = 8,
   parameter int ARADDR_WIDTH = 11,
   parameter int RDATA_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ARID_WIDTH-1:0]   ARID,
   input  logic [ARADDR_WIDTH-1:0] ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic [3:0]              ARREGION,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ARID_WIDTH-1:0]   RID,
   output logic [RDATA_WIDTH-1:0]  RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY,
   output logic                    axi_rd_req,
   output logic [ARADDR_WIDTH-1:0] axi_rd_addr,
   output logic [1:0]              axi_rd_region,
   input  logic [RDATA_WIDTH-1:0]  axi_rd_data,
   input  logic                    fifo_rd_done,
   input  logic                    iram_rd_done,
   input  logic                    wram_rd_done
);

   localparam int PAYLOAD_W = RDATA_WIDTH + ARID_WIDTH + 3;

   rd_state_t                state;
   rd_state_t                state_next;
   logic [ARID_WIDTH-1:0]    id_q;
   logic [ARADDR_WIDTH-1:0]  addr_q;
   logic [ARADDR_WIDTH-1:0]  addr_next;
   logic [ARADDR_WIDTH-1:0]  step;
   logic [7:0]               count_q;
   logic [1:0]               size_q;
   burst_t                   burst_q;
   region_t                  region_q;
`ifdef AXI_RD_WRAP_BURST_EN
   logic [7:0]               len_q;
   logic [ARADDR_WIDTH-1:0]  wrap_mask;
`endif
   logic                     wrap_illegal;
   logic                     err_beat;
   logic                     beat_last;
   logic                     done_any;
   logic                     accept;
   logic                     advance;
   logic                     push_valid;
   logic                     push_ready;
   logic [PAYLOAD_W-1:0]     push_data;
   logic [PAYLOAD_W-1:0]     pop_data;
   logic                     region_unused;

   assign region_unused = ^ARREGION[3:2];
   assign axi_rd_addr   = addr_q;
   assign axi_rd_region = region_q;
   assign beat_last     = (count_q == 8'd0);
   assign done_any      = fifo_rd_done || iram_rd_done || wram_rd_done;
   assign step          = ARADDR_WIDTH'(1) << size_q;

`ifdef AXI_RD_WRAP_BURST_EN
   assign wrap_illegal = (burst_q == BURST_WRAP) &&
                         !(len_q inside {8'd1, 8'd3, 8'd7, 8'd15});
`else
   assign wrap_illegal = 1'b0;
`endif
   assign err_beat = (region_q == REGION_RSVD) || wrap_illegal;

   // Next beat address; WRAP keeps the upper bits of the aligned window and
   // lets only the low bits roll over.
   always_comb begin
      addr_next = addr_q + step;
`ifdef AXI_RD_WRAP_BURST_EN
      wrap_mask = ((ARADDR_WIDTH'(len_q) + ARADDR_WIDTH'(1)) << size_q) - ARADDR_WIDTH'(1);
`endif
      case (burst_q)
         BURST_FIXED: addr_next = addr_q;
`ifdef AXI_RD_WRAP_BURST_EN
         BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
`endif
         default:     ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         id_q     <= '0;
         addr_q   <= '0;
         count_q  <= 8'd0;
         size_q   <= 2'd0;
         burst_q  <= BURST_FIXED;
         region_q <= REGION_FIFO;
`ifdef AXI_RD_WRAP_BURST_EN
         len_q    <= 8'd0;
`endif
      end else begin
         state <= state_next;
         if (accept) begin
            id_q     <= ARID;
            addr_q   <= ARADDR;
            count_q  <= ARLEN;
            size_q   <= clamp_size(ARSIZE);
            burst_q  <= burst_t'(ARBURST);
            region_q <= region_t'(ARREGION[1:0]);
`ifdef AXI_RD_WRAP_BURST_EN
            len_q    <= ARLEN;
`endif
         end else if (advance && !beat_last) begin
            count_q <= count_q - 8'd1;
            addr_q  <= addr_next;
         end
      end
   end

   // Request is combinational in ISSUE so a target answering one cycle later
   // completes a beat every two cycles.
   always_comb begin
      state_next = state;
      ARREADY    = 1'b0;
      axi_rd_req = 1'b0;
      accept     = 1'b0;
      advance    = 1'b0;
      push_valid = 1'b0;
      push_data  = {axi_rd_data, id_q, RESP_OKAY, beat_last};
      case (state)
         IDLE: begin
            ARREADY = 1'b1;
            if (ARVALID) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (push_ready) begin
               if (err_beat) begin
                  push_valid = 1'b1;
                  push_data  = {{RDATA_WIDTH{1'b0}}, id_q, RESP_SLVERR, beat_last};
                  advance    = 1'b1;
                  state_next = beat_last ? DRAIN : ISSUE;
               end else begin
                  axi_rd_req = 1'b1;
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (done_any) begin
               push_valid = 1'b1;
               advance    = 1'b1;
               state_next = beat_last ? DRAIN : ISSUE;
            end
         end
         DRAIN: begin
            if (RVALID && RREADY && RLAST) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   axi_rd_skid_buf #(
      .WIDTH(PAYLOAD_W)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .in_valid (push_valid),
      .in_ready (push_ready),
      .in_data  (push_data),
      .out_valid(RVALID),
      .out_ready(RREADY),
      .out_data (pop_data)
   );

   assign {RDATA, RID, RRESP, RLAST} = pop_data;

endmodule

// File: doc/axi_read_intf.md
Name: axi_read_intf

Overview:
- AXI4 slave read-side interface: accepts AR-channel bursts, generates per-beat addresses, and issues single-beat read requests to the internal targets (FIFO / IRAM / WRAM).
- Returns data on the R channel with RID, RRESP and RLAST.
- Sibling of the write interface. It shares the same internal region encoding and the same done-strobe style of target handshake.
- Allows one burst in flight at a time and one internal request outstanding at a time. A 2-entry R skid buffer absorbs RREADY backpressure.

Parameters:
- ARID_WIDTH, 8, width of ARID/RID.
- ARADDR_WIDTH, 11, byte address width.
- RDATA_WIDTH, 32, data width. Maximum beat size is 4 bytes.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ARID  in  ARID_WIDTH  read burst ID.
- ARADDR  in  ARADDR_WIDTH  burst start byte address.
- ARLEN  in  8  beats minus 1.
- ARSIZE  in  3  log2 bytes per beat.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- ARREGION  in  4  target select; bits [1:0] used.
- ARVALID  in  1  AR valid.
- ARREADY  out  1  AR ready.
- RID  out  ARID_WIDTH  ID of the returned beat.
- RDATA  out  RDATA_WIDTH  read data.
- RRESP  out  2  00 OKAY, 10 SLVERR.
- RLAST  out  1  final beat of burst.
- RVALID  out  1  R valid.
- RREADY  in  1  R ready.
- axi_rd_req  out  1  single-cycle internal read request pulse.
- axi_rd_addr  out  ARADDR_WIDTH  beat address; held stable until done.
- axi_rd_region  out  2  0 FIFO, 1 IRAM, 2 WRAM.
- axi_rd_data  in  RDATA_WIDTH  target data, valid with a done strobe.
- fifo_rd_done  in  1  FIFO read complete.
- iram_rd_done  in  1  IRAM read complete.
- wram_rd_done  in  1  WRAM read complete.

Behaviour:
- Reset values: ARREADY=1; RVALID=0; RLAST=0; RID=0; RDATA=0; RRESP=0; axi_rd_req=0; axi_rd_addr=0; axi_rd_region=0. FSM in IDLE, beat counter 0, skid buffer empty.
- Reset mid-burst: the burst is discarded; no R beat is emitted after reset deasserts.
- FSM has four states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - ARREADY=1.
  - On ARVALID&ARREADY, latch ID, ADDR, LEN, SIZE, BURST and REGION[1:0]; set count=ARLEN; go to ISSUE.
  - ARREADY drops the cycle after the handshake.
- ISSUE:
  - If the skid buffer has at least 1 free entry (counting the outstanding beat), pulse axi_rd_req for 1 cycle and go to WAIT.
  - Exception: region==3 issues no request. It pushes a beat with RDATA=0 and RRESP=SLVERR directly, then advances the beat.
- WAIT:
  - Await any *_rd_done. On done, push {axi_rd_data, OKAY, last=(count==0)}.
  - If count==0 go to DRAIN; else count-1, advance address, go to ISSUE.
  - Done strobes arriving outside WAIT are ignored.
- DRAIN:
  - When the skid buffer is empty and the last beat has handshaken (RVALID&RREADY&RLAST), go to IDLE and raise ARREADY the next cycle.
- Latency: with a target done 1 cycle after the request, the first RVALID occurs 3 cycles after the AR handshake. Steady state is 1 beat per 2 cycles.
- R channel:
  - RVALID/RDATA/RID/RRESP/RLAST are driven from the skid-buffer head.
  - Once RVALID=1, the payload is stable until RREADY.
  - Push and pop in the same cycle is legal; occupancy is unchanged.
  - A push into a full buffer is impossible by construction. An assertion checks this.
- Size: ARSIZE>2 is clamped to 2. Address step = 1<<size, computed in ARADDR_WIDTH bits. Overflow wraps modulo 2^ARADDR_WIDTH.
- FIXED burst: the address is constant for all beats. INCR burst: address += step each beat.
- ARBURST=11 is treated as INCR.
- ARLEN=0 is a single beat with RLAST=1.

Optional Feature:
- Macro: AXI_RD_WRAP_BURST_EN.
- Defined:
  - WRAP bursts are supported. Wrap length = (ARLEN+1)<<size; legal ARLEN values are 1, 3, 7, 15.
  - Address increments and wraps to the aligned boundary floor(ADDR/len)*len.
  - An illegal ARLEN for WRAP returns SLVERR on every beat with no internal requests.
- Undefined: ARBURST=10 is treated as INCR.

Decomposition:
- Shared package:
  - Burst encodings BURST_FIXED/INCR/WRAP.
  - RESP_OKAY/RESP_SLVERR.
  - Region encodings REGION_FIFO/IRAM/WRAM/RSVD.
  - FSM state typedef.
  - Clamp constant SIZE_MAX=2.
- Sub-module: axi_rd_skid_buf, a 2-entry FIFO of {data, id, resp, last} with valid/ready in and out.
- Address generation stays inline.

Test Plan:
- INCR, ARADDR=0x010, ARLEN=3, ARSIZE=2, region 1, iram_rd_done 1 cycle after each req -> axi_rd_addr 0x010, 0x014, 0x018, 0x01C; 4 R beats, RLAST on 4th only, RID=ARID, RRESP=00.
- FIXED, ARADDR=0x020, ARLEN=2, region 0 -> 3 requests, all to 0x020; RLAST on the 3rd beat.
- RREADY held low for 10 cycles mid-burst -> at most 2 beats buffered; no further axi_rd_req; RDATA/RID/RLAST stable; burst completes with no data loss once RREADY=1.
- ARREGION=3, ARLEN=1 -> no axi_rd_req; 2 beats with RDATA=0 and RRESP=10; ARREADY returns to 1 after the last handshake.
- With AXI_RD_WRAP_BURST_EN, WRAP ARADDR=0x038, ARLEN=3, ARSIZE=2 -> addresses 0x038, 0x03C, 0x030, 0x034. Without the macro -> 0x038, 0x03C, 0x040, 0x044.
- rst asserted during WAIT of beat 2 -> all outputs at reset values the same cycle; next AR accepted normally; no stale R beat.
